ring_buffer_write_arbiter: RTL
==============================

Name: ring_buffer_write_arbiter

Overview:
Round-robin burst arbiter that shares the single write port of a ring buffer between NUM_REQ producers, e.g. the CPU store path, debug and DMA feeding one UART TX buffer.
Each producer presents a valid/ready stream.
The arbiter grants one producer at a time and holds the grant for a bounded burst of beats.
It forwards the granted producer's beats into the buffer write port, honouring buffer full.

Parameters:
NUM_REQ, 4, number of producer ports (2..8)
DATA_WIDTH, 8, beat width; must match the buffer
MAX_BURST, 4, maximum beats accepted per grant before forced rotation (>=1)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_req_valid  input  NUM_REQ  per-producer beat valid
i_req_data  input  NUM_REQ*DATA_WIDTH  producer k data in bits [k*DATA_WIDTH +: DATA_WIDTH]
o_req_ready  output  NUM_REQ  per-producer beat accepted this cycle
o_buf_write_en  output  1  write strobe to buffer
o_buf_write_data  output  DATA_WIDTH  write data to buffer
i_buf_full  input  1  buffer full flag
o_grant  output  NUM_REQ  one-hot current grant; all-zero when idle
o_busy  output  1  a grant is held

Behaviour:
- Reset is decided as: i_rst_n, synchronous, active-low; clock i_clk.
- Reset values:
  - state IDLE; o_grant=0; o_busy=0; beat count=0.
  - last-served pointer = NUM_REQ-1, so producer 0 has first priority.
- States: IDLE, GRANT. Grant register, beat counter and last pointer are registered. All outputs are combinational from registers plus current inputs.
- IDLE:
  - o_req_ready=0; o_buf_write_en=0.
  - If any i_req_valid bit is set, pick the first valid index scanning upward from last+1 with wrap.
  - Next cycle: GRANT with that one-hot grant and count=0.
  - Arbitration latency is 1 cycle from valid to grant.
- GRANT, granted index g:
  - o_req_ready[g] = !i_buf_full. All other ready bits are 0.
  - o_buf_write_en = i_req_valid[g] && !i_buf_full.
  - o_buf_write_data = data slice g.
  - A beat transfers when valid[g] && ready[g]; it increments count.
- Release, evaluated each GRANT cycle:
  - (a) transfer with count == MAX_BURST-1, or
  - (b) i_req_valid[g] == 0 (end of burst; costs that cycle, no transfer).
  - On release: last <= g.
    - If any valid among the other producers, go directly to GRANT on the next one in rotation from g+1, count=0.
    - Else if valid[g] is still high (case a), re-grant g with count=0.
    - Else go to IDLE.
  - Result: no bubble between producers when others are waiting.
- Full buffer: i_buf_full=1 stalls the transfer. The count holds and the grant is held. Release happens only by rule (b).
- Full-to-not-full: the transfer happens in the first cycle i_buf_full=0.
- No beat is ever written while i_buf_full=1.
- Producer data must stay stable while valid and not ready. The arbiter does not buffer data; there are zero storage beats.
- o_busy = (state == GRANT).
- Count width: $clog2(MAX_BURST+1). Never exceeds MAX_BURST-1 while registered.
- Reset mid-burst: the grant drops next edge. A beat presented in the reset cycle is not written.
- A producer raising valid while another holds the grant waits. Starvation bound: (NUM_REQ-1)*(MAX_BURST+1) cycles excluding full stalls.

Decomposition:
- Package ring_arb_pkg: state enum arb_state_t {IDLE, GRANT}; rotating-priority helper function.
- One combinational sub-module rr_pick: inputs request vector and last index; outputs one-hot pick and any-valid. Used for both IDLE pick and release hand-off.
- Top instantiates rr_pick and connects directly to ring_buffer's write side (i_write_en, i_write_data, o_full).

Test Plan:
- Reset then valid=4'b0001, data0=0x11,0x12 held two beats, full=0 -> grant=0001 at cycle 1; writes 0x11, 0x12 in cycles 1-2; valid drops -> IDLE, grant=0.
- valid=4'b1111 continuous, MAX_BURST=4 -> grants rotate 0,1,2,3,0; exactly 4 writes each; no idle cycle between grants.
- Producer 2 alone, continuous beats 0x20..0x29 -> 10 writes, re-granted every 4 beats without bubble; last stays 2.
- Grant 1, i_buf_full=1 for 5 cycles mid-burst -> o_buf_write_en=0 and ready=0 throughout; count frozen; resumes with the same beat on full=0; burst still totals 4.
- Producer 0 drops valid after 2 beats while producer 3 is valid -> next cycle grant=1000, count=0.
- Reset asserted during a 4-beat burst of producer 1 -> next cycle grant=0, busy=0; after release producer 0 wins over 1 when both are valid.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// Shared types and the rotating-priority helper for the ring buffer write arbiter.
package ring_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index of the candidate 'offset' places after 'last', wrapping at num_req.
  function automatic int rr_index(input int last, input int offset, input int num_req);
    return (last + offset) % num_req;
  endfunction

endpackage

// File: rtl/ring_buffer_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1 with wrap.
module rr_pick
  import ring_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic               any_valid
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'(rr_index(int'(last), i, NUM_REQ));
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/ring_buffer_write_arbiter.sv
// Round-robin burst arbiter sharing one ring buffer write port between NUM_REQ producers.
module ring_buffer_write_arbiter
  import ring_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_buf_write_en,
  output logic [DATA_WIDTH-1:0]         o_buf_write_data,
  input  logic                          i_buf_full,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_last;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               granted_valid;
  logic               xfer;
  logic               release_now;

  assign grant_oh      = NUM_REQ'(1) << grant_q;
  assign granted_valid = i_req_valid[grant_q];

  assign o_busy           = (state_q == GRANT);
  assign o_grant          = o_busy ? grant_oh : '0;
  assign o_buf_write_data = i_req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  // Gated by reset so a beat presented in the reset cycle is neither accepted nor written.
  assign o_req_ready      = (o_busy && i_rst_n && !i_buf_full) ? grant_oh : '0;
  assign o_buf_write_en   = o_busy && i_rst_n && !i_buf_full && granted_valid;

  assign xfer        = o_buf_write_en;
  assign release_now = o_busy && ((xfer && (count_q == LAST_BEAT)) || !granted_valid);

  // One picker serves both the idle pick and the hand-off, which excludes the holder.
  assign pick_req  = o_busy ? (i_req_valid & ~grant_oh) : i_req_valid;
  assign pick_last = o_busy ? grant_q : last_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (pick_req),
    .last      (pick_last),
    .pick      (pick_oh),
    .any_valid (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_idx;
          count_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_d  = grant_q;
          count_d = '0;
          if (pick_any) begin
            grant_d = pick_idx;
          end else if (!granted_valid) begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

endmodule
